// File: rtl/host_msix_capture.sv
// host_msix_capture: MSI-X capture engine for the host memory model.
// Snoops host DW writes, matches them against a table of (address, data) vectors, and tracks
// per-vector pending/overflow/hit-count state. Unmasked pending vectors are handed to the
// consumer through a valid/ready event port, lowest index first.
module host_msix_capture #(
  parameter int unsigned NUM_VEC = 8,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IdxW   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               cfg_we,
  input  logic [IdxW-1:0]    cfg_idx,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_data,
  input  logic               cfg_en,
  input  logic               cfg_mask,
  output logic               evt_valid,
  output logic [IdxW-1:0]    evt_vec,
  input  logic               evt_ready,
  output logic [NUM_VEC-1:0] pending,
  output logic [NUM_VEC-1:0] overflow,
  input  logic [IdxW-1:0]    cnt_sel,
  output logic [CNT_W-1:0]   cnt_val
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Stage 1 registers
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_data_q;

  // Vector table
  logic [NUM_VEC-1:0] en_q, en_d;
  logic [NUM_VEC-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]  addr_q [NUM_VEC];
  logic [DATA_W-1:0]  data_q [NUM_VEC];

  // Per-vector status
  logic [NUM_VEC-1:0] pending_q, pending_d;
  logic [NUM_VEC-1:0] overflow_q, overflow_d;
  logic [CNT_W-1:0]   cnt_q [NUM_VEC];
  logic [CNT_W-1:0]   cnt_d [NUM_VEC];

  // Event port
  logic               evt_valid_q, evt_valid_d;
  logic [IdxW-1:0]    evt_vec_q, evt_vec_d;
  logic [NUM_VEC-1:0] elig;

  logic               pop;
  logic [NUM_VEC-1:0] hit;
  logic [NUM_VEC-1:0] pop_oh;
  logic [NUM_VEC-1:0] cfg_oh;

  assign pop = evt_valid_q & evt_ready;

  // Stage 1: register the snooped write; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= wr_valid;
      s1_addr_q  <= wr_addr;
      s1_data_q  <= wr_data;
    end
  end

  // Stage 2 compare against the current table, plus pop/config one-hot decode
  always_comb begin
    hit    = '0;
    pop_oh = '0;
    cfg_oh = '0;
    for (int unsigned v = 0; v < NUM_VEC; v++) begin
      hit[v]    = s1_valid_q && en_q[v] && (addr_q[v] == s1_addr_q) && (data_q[v] == s1_data_q);
      pop_oh[v] = pop && (32'(evt_vec_q) == v);
      cfg_oh[v] = cfg_we && (32'(cfg_idx) == v);
    end
  end

  // Next-state for table flags, pending, overflow and counters
  always_comb begin
    en_d       = en_q;
    mask_d     = mask_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    for (int unsigned v = 0; v < NUM_VEC; v++) begin
      cnt_d[v] = cnt_q[v];
      if (hit[v]) begin
        // A hit on the vector being popped this cycle re-arms it rather than overflowing.
        if (pending_q[v] && !pop_oh[v]) begin
          overflow_d[v] = 1'b1;
        end
        pending_d[v] = 1'b1;
        if (cnt_q[v] != CntMax) begin
          cnt_d[v] = cnt_q[v] + CntOne;
        end
      end else if (pop_oh[v]) begin
        pending_d[v] = 1'b0;
      end
      // Disabling an entry drops its pending bit, even over a same-cycle hit on the old entry.
      if (cfg_oh[v]) begin
        en_d[v]   = cfg_en;
        mask_d[v] = cfg_mask;
        if (!cfg_en) begin
          pending_d[v] = 1'b0;
        end
      end
    end
  end

  // Event selection from next state so evt_* lines up with the registered pending bits
  always_comb begin
    elig        = pending_d & ~mask_d & en_d;
    evt_valid_d = |elig;
    evt_vec_d   = '0;
    for (int v = int'(NUM_VEC) - 1; v >= 0; v--) begin
      if (elig[v]) begin
        evt_vec_d = IdxW'(v);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= '0;
      mask_q      <= '0;
      pending_q   <= '0;
      overflow_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_vec_q   <= '0;
      for (int unsigned v = 0; v < NUM_VEC; v++) begin
        addr_q[v] <= '0;
        data_q[v] <= '0;
        cnt_q[v]  <= '0;
      end
    end else begin
      en_q        <= en_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      evt_valid_q <= evt_valid_d;
      evt_vec_q   <= evt_vec_d;
      for (int unsigned v = 0; v < NUM_VEC; v++) begin
        cnt_q[v] <= cnt_d[v];
        if (cfg_oh[v]) begin
          addr_q[v] <= cfg_addr;
          data_q[v] <= cfg_data;
        end
      end
    end
  end

  // Counter read mux; out-of-range selects read as zero
  always_comb begin
    cnt_val = '0;
    for (int unsigned v = 0; v < NUM_VEC; v++) begin
      if (32'(cnt_sel) == v) begin
        cnt_val = cnt_q[v];
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_vec   = evt_vec_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_host_msix_capture.sv
// Bench for host_msix_capture: directed scenarios plus randomized traffic, all checked against
// a cycle-level behavioural model. Popped events are checked through a scoreboard queue.
module tb_host_msix_capture;

  localparam int NV     = 8;
  localparam int AW     = 64;
  localparam int DW     = 32;
  localparam int CW     = 4;
  localparam int IW     = 3;
  localparam int CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_en;
  logic          cfg_mask;
  logic          evt_valid;
  logic [IW-1:0] evt_vec;
  logic          evt_ready;
  logic [NV-1:0] pending;
  logic [NV-1:0] overflow;
  logic [IW-1:0] cnt_sel;
  logic [CW-1:0] cnt_val;

  host_msix_capture #(
    .NUM_VEC(NV),
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_en   (cfg_en),
    .cfg_mask (cfg_mask),
    .evt_valid(evt_valid),
    .evt_vec  (evt_vec),
    .evt_ready(evt_ready),
    .pending  (pending),
    .overflow (overflow),
    .cnt_sel  (cnt_sel),
    .cnt_val  (cnt_val)
  );

  always #5 clk = ~clk;

  // Reference model state: the table, per-vector status and the one write waiting to be compared
  bit            m_en   [NV];
  bit            m_mask [NV];
  logic [AW-1:0] m_addr [NV];
  logic [DW-1:0] m_data [NV];
  bit            m_pend [NV];
  bit            m_ovf  [NV];
  int            m_cnt  [NV];
  bit            m_s1v;
  logic [AW-1:0] m_s1a;
  logic [DW-1:0] m_s1d;

  int exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lowest-numbered vector that is pending, enabled and unmasked; -1 if none
  function automatic int m_evt();
    for (int v = 0; v < NV; v++) begin
      if (m_pend[v] && !m_mask[v] && m_en[v]) return v;
    end
    return -1;
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    int p;
    bit hit [NV];
    if (rst) begin
      for (int v = 0; v < NV; v++) begin
        m_en[v]   = 1'b0;
        m_mask[v] = 1'b0;
        m_addr[v] = '0;
        m_data[v] = '0;
        m_pend[v] = 1'b0;
        m_ovf[v]  = 1'b0;
        m_cnt[v]  = 0;
      end
      m_s1v = 1'b0;
    end else begin
      p = evt_ready ? m_evt() : -1;
      if (p >= 0) exp_q.push_back(p);
      for (int v = 0; v < NV; v++) begin
        hit[v] = m_s1v && m_en[v] && (m_addr[v] == m_s1a) && (m_data[v] == m_s1d);
      end
      for (int v = 0; v < NV; v++) begin
        if (hit[v]) begin
          if (m_pend[v] && p != v) m_ovf[v] = 1'b1;
          m_pend[v] = 1'b1;
          if (m_cnt[v] < CntMax) m_cnt[v]++;
        end else if (p == v) begin
          m_pend[v] = 1'b0;
        end
      end
      if (cfg_we) begin
        m_en[cfg_idx]   = cfg_en;
        m_mask[cfg_idx] = cfg_mask;
        m_addr[cfg_idx] = cfg_addr;
        m_data[cfg_idx] = cfg_data;
        if (!cfg_en) m_pend[cfg_idx] = 1'b0;
      end
      m_s1v = wr_valid;
      m_s1a = wr_addr;
      m_s1d = wr_data;
    end
  endtask

  task automatic compare_all();
    logic [NV-1:0] mp;
    logic [NV-1:0] mo;
    int e;
    for (int v = 0; v < NV; v++) begin
      mp[v] = m_pend[v];
      mo[v] = m_ovf[v];
    end
    e = m_evt();
    check("pending", 64'(pending), 64'(mp));
    check("overflow", 64'(overflow), 64'(mo));
    check("evt_valid", 64'(evt_valid), 64'(e >= 0));
    if (e >= 0) check("evt_vec", 64'(evt_vec), 64'(e));
    check("cnt_val", 64'(cnt_val), 64'(m_cnt[cnt_sel]));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cnt_sel = IW'($urandom_range(0, NV - 1));
    #1;
    compare_all();
  endtask

  task automatic idle();
    wr_valid  = 1'b0;
    cfg_we    = 1'b0;
    evt_ready = 1'b0;
  endtask

  task automatic cfg(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit en, input bit mk);
    idle();
    cfg_we   = 1'b1;
    cfg_idx  = IW'(idx);
    cfg_addr = a;
    cfg_data = d;
    cfg_en   = en;
    cfg_mask = mk;
    step();
    idle();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rdy);
    idle();
    wr_valid  = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    evt_ready = rdy;
    step();
    idle();
  endtask

  task automatic wait_n(input int n, input bit rdy);
    repeat (n) begin
      idle();
      evt_ready = rdy;
      step();
    end
    idle();
  endtask

  task automatic peek(input int sel);
    cnt_sel = IW'(sel);
    #1;
  endtask

  // Monitor: every accepted event must match the next vector the model handed out
  always @(negedge clk) begin : mon
    int e;
    if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL evt_pop: got vector %0d, expected no transfer (t=%0t)", evt_vec, $time);
      end else begin
        e = exp_q.pop_front();
        check("evt_pop", 64'(evt_vec), 64'(e));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    cnt_sel  = '0;
    cfg_idx  = '0;
    cfg_addr = '0;
    cfg_data = '0;
    cfg_en   = 1'b0;
    cfg_mask = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    idle();
    @(posedge clk);
    #2;

    // Reset
    wait_n(3, 1'b0);
    check("rst_evt_vec", 64'(evt_vec), 64'd0);
    check("rst_evt_valid", 64'(evt_valid), 64'd0);
    rst = 1'b0;
    wait_n(1, 1'b0);

    // Single vector: two-cycle latency, count of one
    cfg(0, 64'h1, 32'h1234_5678, 1'b1, 1'b0);
    wr(64'h1, 32'h1234_5678, 1'b0);
    check("t1_not_early", 64'(pending[0]), 64'd0);
    wait_n(1, 1'b0);
    check("t1_pending0", 64'(pending[0]), 64'd1);
    check("t1_evt_valid", 64'(evt_valid), 64'd1);
    check("t1_evt_vec", 64'(evt_vec), 64'd0);
    peek(0);
    check("t1_cnt0", 64'(cnt_val), 64'd1);
    wait_n(1, 1'b1);

    // Two vectors: lowest first, held while not ready
    cfg(2, 64'h100, 32'hA2, 1'b1, 1'b0);
    cfg(5, 64'h200, 32'hA5, 1'b1, 1'b0);
    wr(64'h100, 32'hA2, 1'b0);
    wr(64'h200, 32'hA5, 1'b0);
    wait_n(3, 1'b0);
    check("t2_first", 64'(evt_vec), 64'd2);
    wait_n(1, 1'b1);
    check("t2_second", 64'(evt_vec), 64'd5);
    wait_n(1, 1'b1);
    check("t2_done_valid", 64'(evt_valid), 64'd0);
    check("t2_done_pending", 64'(pending), 64'd0);

    // Masked vector pends silently, then becomes eligible once unmasked
    cfg(3, 64'h300, 32'hA3, 1'b1, 1'b1);
    wr(64'h300, 32'hA3, 1'b0);
    wait_n(2, 1'b0);
    check("t3_pending3", 64'(pending[3]), 64'd1);
    check("t3_masked", 64'(evt_valid), 64'd0);
    cfg(3, 64'h300, 32'hA3, 1'b1, 1'b0);
    check("t3_unmasked_valid", 64'(evt_valid), 64'd1);
    check("t3_unmasked_vec", 64'(evt_vec), 64'd3);
    wait_n(1, 1'b1);

    // Double hit overflows; hit coinciding with pop keeps pending
    cfg(1, 64'h180, 32'hA1, 1'b1, 1'b0);
    wr(64'h180, 32'hA1, 1'b0);
    wr(64'h180, 32'hA1, 1'b0);
    wait_n(2, 1'b0);
    check("t4_overflow1", 64'(overflow[1]), 64'd1);
    peek(1);
    check("t4_cnt1", 64'(cnt_val), 64'd2);
    wr(64'h180, 32'hA1, 1'b0);
    wait_n(1, 1'b1);
    check("t4_hit_pop_pending", 64'(pending[1]), 64'd1);
    wait_n(1, 1'b1);
    check("t4_popped", 64'(pending[1]), 64'd0);
    cfg(6, 64'h600, 32'hA6, 1'b1, 1'b0);
    wr(64'h600, 32'hA6, 1'b0);
    wait_n(2, 1'b0);
    wr(64'h600, 32'hA6, 1'b0);
    wait_n(1, 1'b1);
    check("t4_no_overflow6", 64'(overflow[6]), 64'd0);
    check("t4_pending6", 64'(pending[6]), 64'd1);
    wait_n(1, 1'b1);

    // Counter saturation
    cfg(4, 64'h400, 32'hA4, 1'b1, 1'b1);
    repeat (20) wr(64'h400, 32'hA4, 1'b0);
    wait_n(2, 1'b0);
    peek(4);
    check("t5_cnt4_sat", 64'(cnt_val), 64'd15);

    // Near-miss data and disabled entry capture nothing
    wr(64'h1, 32'h1234_5679, 1'b0);
    wait_n(2, 1'b0);
    check("t6_near_miss", 64'(pending[0]), 64'd0);
    cfg(7, 64'h700, 32'hA7, 1'b0, 1'b0);
    wr(64'h700, 32'hA7, 1'b0);
    wait_n(2, 1'b0);
    check("t6_disabled", 64'(pending[7]), 64'd0);

    // Reset with a write sitting in stage 1 and another presented during reset
    wr(64'h1, 32'h1234_5678, 1'b0);
    rst       = 1'b1;
    wr_valid  = 1'b1;
    wr_addr   = 64'h1;
    wr_data   = 32'h1234_5678;
    step();
    rst = 1'b0;
    wait_n(3, 1'b0);
    check("t7_pending", 64'(pending), 64'd0);
    check("t7_overflow", 64'(overflow), 64'd0);
    check("t7_evt_valid", 64'(evt_valid), 64'd0);
    peek(0);
    check("t7_cnt0", 64'(cnt_val), 64'd0);

    // Randomized traffic over a small address/data pool so hits and duplicates are common
    for (int v = 0; v < NV; v++) begin
      cfg(v, 64'(32'h1000 + 32'h10 * $urandom_range(0, 3)), 32'($urandom_range(1, 3)),
          $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
    end
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      wr_valid  = ($urandom_range(0, 9) < 7);
      wr_addr   = 64'(32'h1000 + 32'h10 * $urandom_range(0, 3));
      wr_data   = 32'($urandom_range(1, 3));
      cfg_we    = ($urandom_range(0, 19) == 0);
      cfg_idx   = IW'($urandom_range(0, NV - 1));
      cfg_addr  = 64'(32'h1000 + 32'h10 * $urandom_range(0, 3));
      cfg_data  = 32'($urandom_range(1, 3));
      cfg_en    = ($urandom_range(0, 9) < 8);
      cfg_mask  = ($urandom_range(0, 9) < 3);
      evt_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    rst = 1'b0;
    wait_n(4, 1'b0);
    check("evt_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/host_msix_capture.md
Name: host_msix_capture

Overview:
- Synthesizable, parametrised MSI-X capture engine for the host memory model.
- Snoops every DW write the host memory receives and matches each against a programmable table of NUM_VEC (address, data) vector entries.
- Tracks per-vector pending, mask and hit-count state, and delivers unmasked pending vectors to the test bench through a valid/ready event port.
- Replaces the single hard-coded flag (address 0x1, data 0x12345678) with a multi-vector, clearable capture engine.

Parameters:
NUM_VEC, 8, number of vector table entries (1..64)
ADDR_W, 64, host address width
DATA_W, 32, message data width
CNT_W, 16, per-vector hit counter width (saturating)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  host DW write strobe; always accepted, no backpressure
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
cfg_we  in  1  vector table write strobe
cfg_idx  in  $clog2(NUM_VEC)  table entry index
cfg_addr  in  ADDR_W  entry match address
cfg_data  in  DATA_W  entry match data
cfg_en  in  1  entry valid
cfg_mask  in  1  entry mask
evt_valid  out  1  an unmasked pending vector is available
evt_vec  out  $clog2(NUM_VEC)  index of the lowest-numbered unmasked pending vector
evt_ready  in  1  consumer accepts the event; the pending bit is cleared
pending  out  NUM_VEC  pending bits
overflow  out  NUM_VEC  sticky: a hit arrived while the vector was already pending
cnt_sel  in  $clog2(NUM_VEC)  counter read select
cnt_val  out  CNT_W  hit count of vector cnt_sel, combinational read

Behaviour:
- Reset: all table entries cleared (en=0, mask=0, addr=0, data=0).
  - pending, overflow and all counters are 0; evt_valid=0; evt_vec=0.
  - Reset mid-pipeline discards in-flight writes; nothing is captured from writes presented in the cycle rst is high.
- Pipeline, 2 stages:
  - S1 registers wr_valid/addr/data.
  - S2 compares the registered write against all entries in parallel (exact match on the full ADDR_W and DATA_W, entry en=1) and updates state.
  - A write at cycle N is visible on pending, counters and evt_valid at cycle N+2.
  - Throughput is one write per cycle.
- Hit on vector v:
  - pending[v] <= 1.
  - Counter v increments and saturates at 2^CNT_W-1.
  - If pending[v] was already 1, overflow[v] <= 1 (sticky until reset).
  - Multiple entries matching the same write all register hits.
- Mask: masked vectors still set pending and count, but are excluded from evt selection. Clearing a mask on a pending vector makes it eligible the next cycle.
- Event port:
  - evt_valid = OR of (pending & ~mask & en).
  - evt_vec = lowest such index, registered and updated each cycle.
  - Transfer occurs when evt_valid && evt_ready; the pending bit of evt_vec is cleared on the next edge.
  - evt_vec is held stable while evt_valid=1 and evt_ready=0, unless a lower-index vector becomes eligible. A lower index takes priority; the spec permits a change while not yet accepted.
- Simultaneous hit and pop on the same vector in one cycle: the hit wins, pending stays 1, overflow is not set, and the count increments.
- cfg_we:
  - Takes effect for comparisons starting the next cycle.
  - Writing en=0 also clears pending[v]; the counter and overflow are kept.
  - A cfg_we to the vector being popped in the same cycle: the pop is completed and the config is applied.
  - A cfg_we colliding with a same-cycle S2 hit: the hit uses the old entry.
- Counters wrap: never; they saturate.
- cnt_sel out of range (>= NUM_VEC) returns 0.

Test Plan:
- Program entry 0 = (0x1, 0x12345678, en=1), write addr 0x1 data 0x12345678 at cycle 10 -> pending[0]=1 and evt_valid=1 with evt_vec=0 at cycle 12; cnt_val(0)=1.
- Program entries 2 and 5 unmasked, hit both in consecutive cycles, hold evt_ready=0 then assert it -> evt_vec=2 first, then 5, then evt_valid=0; pending=0.
- Entry 3 masked, hit it -> pending[3]=1, evt_valid=0; clear the mask -> evt_valid=1 with evt_vec=3 the next cycle.
- Hit entry 1 twice without popping -> overflow[1]=1, cnt_val(1)=2. A hit coinciding with a pop of vector 1 -> pending[1] remains 1.
- CNT_W=4, 20 hits to entry 4 -> cnt_val(4)=15 (saturated).
- Non-matching data (0x12345679) or an entry with en=0 -> no pending change. Assert rst with a write in S1 -> all outputs 0 and nothing is captured after reset.
